// File: rtl/fpu_cmp_responder.sv
//------------------------------------------------------------------------------
// fpu_cmp_responder : single-precision compare responder for the FPU
//                     decode/execute/flush handshake; other opcodes pass opA.
// Option macro      : FPU_CMP_DAZ_EN (denormal operands compare as signed zero)
// Revision          : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fpu_cmp_responder #(
    parameter int LATENCY            = 3,
    parameter int OR1K_FPUOP_WIDTH   = 8,
    parameter int OR1K_FPCSR_RM_SIZE = 2,
    parameter int OR1K_FPCSR_WIDTH   = 12
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          flush,
    input  logic                          decode,
    input  logic                          execute,
    input  logic [OR1K_FPUOP_WIDTH-1:0]   fpuOp,
    input  logic [OR1K_FPCSR_RM_SIZE-1:0] rounding,
    input  logic [31:0]                   opA,
    input  logic [31:0]                   opB,
    output logic [31:0]                   fpuOut,
    output logic                          validarithmetic,
    output logic                          compare,
    output logic                          validcompare,
    output logic [OR1K_FPCSR_WIDTH-1:0]   fpcsr
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_DECODED = 2'd1;
    localparam logic [1:0] S_BUSY    = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [3:0] C_CNT_LOAD = 4'(LATENCY - 1);

    logic [1:0]                    r_state;
    logic [3:0]                    r_cnt;
    logic [31:0]                   r_opa;
    logic [31:0]                   r_opb;
    logic [3:0]                    r_op;
    logic [OR1K_FPCSR_RM_SIZE-1:0] r_rm;

    logic [31:0]                   r_fpuout;
    logic                          r_valid_ar;
    logic                          r_valid_cmp;
    logic                          r_compare;
    logic [OR1K_FPCSR_WIDTH-1:0]   r_fpcsr;

    // Opcode bits above the compare selector do not affect behaviour.
    logic w_unused;
    assign w_unused = ^fpuOp[OR1K_FPUOP_WIDTH-1:4];

    logic        w_a_nan, w_b_nan, w_a_snan, w_b_snan, w_any_nan, w_any_snan;
    logic [30:0] w_a_mag, w_b_mag;
    logic        w_a_zero, w_b_zero, w_eq, w_lt, w_gt;
    logic        w_rsv, w_ord, w_cmp;
    logic [OR1K_FPCSR_WIDTH-1:0] w_csr_cmp;
    logic [OR1K_FPCSR_WIDTH-1:0] w_csr_ar;

    assign w_a_nan    = (r_opa[30:23] == 8'hFF) && (r_opa[22:0] != 23'd0);
    assign w_b_nan    = (r_opb[30:23] == 8'hFF) && (r_opb[22:0] != 23'd0);
    assign w_a_snan   = w_a_nan && !r_opa[22];
    assign w_b_snan   = w_b_nan && !r_opb[22];
    assign w_any_nan  = w_a_nan || w_b_nan;
    assign w_any_snan = w_a_snan || w_b_snan;

`ifdef FPU_CMP_DAZ_EN
    assign w_a_mag = (r_opa[30:23] == 8'd0) ? 31'd0 : r_opa[30:0];
    assign w_b_mag = (r_opb[30:23] == 8'd0) ? 31'd0 : r_opb[30:0];
`else
    assign w_a_mag = r_opa[30:0];
    assign w_b_mag = r_opb[30:0];
`endif

    assign w_a_zero = (w_a_mag == 31'd0);
    assign w_b_zero = (w_b_mag == 31'd0);

    // Sign-magnitude ordering; both zeros are equal regardless of sign.
    assign w_eq = (w_a_zero && w_b_zero) ||
                  ((r_opa[31] == r_opb[31]) && (w_a_mag == w_b_mag));
    assign w_lt = !w_eq &&
                  ((r_opa[31] != r_opb[31]) ? r_opa[31] :
                   (r_opa[31] ? (w_a_mag > w_b_mag) : (w_a_mag < w_b_mag)));
    assign w_gt = !w_eq && !w_lt;

    assign w_rsv = (r_op[2:1] == 2'b11);
    assign w_ord = (r_op[2:0] >= 3'd2) && !w_rsv;

    always_comb begin
        w_cmp = 1'b0;
        case (r_op[2:0])
            3'd0:    w_cmp = w_eq;
            3'd1:    w_cmp = !w_eq;
            3'd2:    w_cmp = w_gt;
            3'd3:    w_cmp = w_gt || w_eq;
            3'd4:    w_cmp = w_lt;
            3'd5:    w_cmp = w_lt || w_eq;
            default: w_cmp = 1'b0;
        endcase
        if (w_any_nan) begin
            w_cmp = (r_op[2:0] == 3'd1);
        end
    end

    always_comb begin
        w_csr_ar = '0;
        w_csr_ar[OR1K_FPCSR_RM_SIZE:1] = r_rm;
        w_csr_cmp    = w_csr_ar;
        w_csr_cmp[5] = w_any_snan;
        w_csr_cmp[6] = w_any_nan;
        w_csr_cmp[9] = w_rsv || (w_any_nan && (w_ord || w_any_snan));
    end

    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_opa       <= 32'd0;
            r_opb       <= 32'd0;
            r_op        <= 4'd0;
            r_rm        <= '0;
            r_fpuout    <= 32'd0;
            r_valid_ar  <= 1'b0;
            r_valid_cmp <= 1'b0;
            r_compare   <= 1'b0;
            r_fpcsr     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (decode) begin
                        r_state <= S_DECODED;
                    end
                end
                S_DECODED: begin
                    if (execute) begin
                        r_opa   <= opA;
                        r_opb   <= opB;
                        r_op    <= fpuOp[3:0];
                        r_rm    <= rounding;
                        r_cnt   <= C_CNT_LOAD;
                        r_state <= S_BUSY;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_DONE;
                        if (r_op[3]) begin
                            r_valid_cmp <= 1'b1;
                            r_compare   <= w_cmp;
                            r_fpuout    <= 32'd0;
                            r_fpcsr     <= w_csr_cmp;
                        end else begin
                            r_valid_ar  <= 1'b1;
                            r_compare   <= 1'b0;
                            r_fpuout    <= r_opa;
                            r_fpcsr     <= w_csr_ar;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    if (decode) begin
                        r_valid_ar  <= 1'b0;
                        r_valid_cmp <= 1'b0;
                        r_state     <= S_DECODED;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign fpuOut          = r_fpuout;
    assign validarithmetic = r_valid_ar;
    assign compare         = r_compare;
    assign validcompare    = r_valid_cmp;
    assign fpcsr           = r_fpcsr;

endmodule

`default_nettype wire

// File: tb/tb_fpu_cmp_responder.sv
//------------------------------------------------------------------------------
// tb_fpu_cmp_responder : directed bench with an ordering-key reference model.
// Revision             : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fpu_cmp_responder;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        decode = 1'b0;
    logic        execute = 1'b0;
    logic [7:0]  fpuOp = 8'd0;
    logic [1:0]  rounding = 2'd0;
    logic [31:0] opA = 32'd0;
    logic [31:0] opB = 32'd0;
    logic [31:0] fpuOut;
    logic        validarithmetic;
    logic        compare;
    logic        validcompare;
    logic [11:0] fpcsr;

    always #5 clk = ~clk;

    fpu_cmp_responder #(.LATENCY(LAT)) u_dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .flush           (flush),
        .decode          (decode),
        .execute         (execute),
        .fpuOp           (fpuOp),
        .rounding        (rounding),
        .opA             (opA),
        .opB             (opB),
        .fpuOut          (fpuOut),
        .validarithmetic (validarithmetic),
        .compare         (compare),
        .validcompare    (validcompare),
        .fpcsr           (fpcsr)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: map each float to a signed integer key so that ordering
    // becomes ordinary integer comparison (+0 and -0 both map to 0).
    function automatic longint fkey(input logic [31:0] x);
        longint m;
        m = longint'(x[30:0]);
`ifdef FPU_CMP_DAZ_EN
        if (x[30:23] == 8'd0) m = 0;
`endif
        return x[31] ? -m : m;
    endfunction

    function automatic logic [12:0] ref_cmp(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [1:0] rm);
        longint ka, kb;
        bit na, nb, anyn, anys;
        logic c;
        logic [11:0] f;
        ka = fkey(a);
        kb = fkey(b);
        na = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        nb = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        anyn = na || nb;
        anys = (na && !a[22]) || (nb && !b[22]);
        case (op[2:0])
            3'd0: c = (ka == kb);
            3'd1: c = (ka != kb);
            3'd2: c = (ka > kb);
            3'd3: c = (ka >= kb);
            3'd4: c = (ka < kb);
            3'd5: c = (ka <= kb);
            default: c = 1'b0;
        endcase
        if (anyn) c = (op[2:0] == 3'd1);
        f = 12'd0;
        f[2:1] = rm;
        f[5] = anys;
        f[6] = anyn;
        f[9] = (op[2:0] >= 3'd6) || (anyn && (op[2:0] >= 3'd2 || anys));
        return {c, f};
    endfunction

    // Timeline model: an accepted execute completes LAT edges later.
    longint      cyc = 0;
    longint      m_due = 0;
    bit          m_ann = 0, m_busy = 0;
    logic [3:0]  m_op = 0;
    logic [31:0] m_a = 0, m_b = 0;
    logic [1:0]  m_rm = 0;
    logic        m_va = 0, m_vc = 0, m_cmp = 0;
    logic [31:0] m_out = 0;
    logic [11:0] m_csr = 0;
    logic [12:0] m_res;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset_n || flush) begin
            m_ann <= 0; m_busy <= 0;
            m_va <= 0; m_vc <= 0; m_cmp <= 0; m_out <= 0; m_csr <= 0;
        end else if (m_busy) begin
            if (cyc == m_due) begin
                m_busy <= 0;
                if (m_op[3]) begin
                    m_res = ref_cmp(m_op, m_a, m_b, m_rm);
                    m_vc  <= 1; m_cmp <= m_res[12]; m_csr <= m_res[11:0]; m_out <= 0;
                end else begin
                    m_va  <= 1; m_cmp <= 0; m_csr <= {9'd0, m_rm, 1'b0}; m_out <= m_a;
                end
            end
        end else if (m_ann) begin
            m_ann <= 0;
            if (execute) begin
                m_busy <= 1; m_due <= cyc + LAT;
                m_op <= fpuOp[3:0]; m_a <= opA; m_b <= opB; m_rm <= rounding;
            end
        end else if (decode) begin
            m_ann <= 1; m_va <= 0; m_vc <= 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model.validarithmetic", {31'd0, validarithmetic}, {31'd0, m_va});
            chk("model.validcompare", {31'd0, validcompare}, {31'd0, m_vc});
            chk("model.compare", {31'd0, compare}, {31'd0, m_cmp});
            chk("model.fpuOut", fpuOut, m_out);
            chk("model.fpcsr", {20'd0, fpcsr}, {20'd0, m_csr});
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [7:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [1:0] rm);
        fpuOp = op; opA = a; opB = b; rounding = rm;
        decode = 1'b1;
        tick;
        decode = 1'b0;
        execute = 1'b1;
        tick;
        execute = 1'b0;
        // Scramble inputs so results must come from captured operands.
        fpuOp = ~op; opA = ~a; opB = ~b; rounding = ~rm;
    endtask

    task automatic do_op(input string nm, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [1:0] rm, input logic exp_cmp,
                         input logic [11:0] exp_csr, input logic [31:0] exp_out);
        int n;
        start_op(op, a, b, rm);
        n = 0;
        while (!(validcompare || validarithmetic) && n < 20) begin
            tick;
            n++;
        end
        chk({nm, ".latency"}, n, LAT);
        chk({nm, ".validcompare"}, {31'd0, validcompare}, {31'd0, op[3]});
        chk({nm, ".validarithmetic"}, {31'd0, validarithmetic}, {31'd0, !op[3]});
        chk({nm, ".compare"}, {31'd0, compare}, {31'd0, exp_cmp});
        chk({nm, ".fpcsr"}, {20'd0, fpcsr}, {20'd0, exp_csr});
        chk({nm, ".fpuOut"}, fpuOut, exp_out);
    endtask

    task automatic expect_idle(input string nm, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            tick;
            chk({nm, ".no_valid"}, {30'd0, validcompare, validarithmetic}, 32'd0);
            chk({nm, ".outs_zero"}, fpuOut | {20'd0, fpcsr} | {31'd0, compare}, 32'd0);
        end
    endtask

    initial begin
        repeat (3) tick;
        chk("reset.fpuOut", fpuOut, 32'd0);
        chk("reset.valids", {30'd0, validcompare, validarithmetic}, 32'd0);
        chk("reset.compare_fpcsr", {19'd0, compare, fpcsr}, 32'd0);
        reset_n = 1'b1;
        chk_en = 1'b1;
        tick;

        do_op("sflt_1_2", 8'h0C, 32'h3F800000, 32'h40000000, 2'd0, 1'b1, 12'h000, 32'd0);
        do_op("sfeq_pz_nz", 8'h08, 32'h00000000, 32'h80000000, 2'd0, 1'b1, 12'h000, 32'd0);
        do_op("sfgt_pz_nz", 8'h0A, 32'h00000000, 32'h80000000, 2'd0, 1'b0, 12'h000, 32'd0);
        do_op("sfeq_qnan", 8'h08, 32'h7FC00000, 32'h3F800000, 2'd0, 1'b0, 12'h040, 32'd0);
        do_op("sflt_qnan", 8'h0C, 32'h7FC00000, 32'h3F800000, 2'd0, 1'b0, 12'h240, 32'd0);
        do_op("sfne_snan", 8'h09, 32'h7F800001, 32'h3F800000, 2'd0, 1'b1, 12'h260, 32'd0);
        do_op("sflt_neg", 8'h0C, 32'hBF800000, 32'hC0000000, 2'd1, 1'b0, 12'h002, 32'd0);
        do_op("sfgt_neg", 8'h0A, 32'hBF800000, 32'hC0000000, 2'd3, 1'b1, 12'h006, 32'd0);
        do_op("sfge_eq", 8'h0B, 32'h3F800000, 32'h3F800000, 2'd0, 1'b1, 12'h000, 32'd0);
        do_op("sfle_mix", 8'h0D, 32'h40000000, 32'hBF800000, 2'd0, 1'b0, 12'h000, 32'd0);
        do_op("reserved6", 8'h0E, 32'h3F800000, 32'h40000000, 2'd0, 1'b0, 12'h200, 32'd0);
`ifdef FPU_CMP_DAZ_EN
        do_op("denorm_eq", 8'h08, 32'h00000001, 32'h00000000, 2'd0, 1'b1, 12'h000, 32'd0);
`else
        do_op("denorm_eq", 8'h08, 32'h00000001, 32'h00000000, 2'd0, 1'b0, 12'h000, 32'd0);
`endif
        do_op("passthru", 8'h00, 32'h12345678, 32'h0, 2'd2, 1'b0, 12'h004, 32'h12345678);

        flush = 1'b1;
        tick;
        flush = 1'b0;
        chk("flush.fpuOut", fpuOut, 32'd0);
        chk("flush.valid", {31'd0, validarithmetic}, 32'd0);

        // Abort one cycle after execute.
        start_op(8'h0C, 32'h3F800000, 32'h40000000, 2'd1);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        expect_idle("abort_flush", 6);
        do_op("after_flush", 8'h0C, 32'h3F800000, 32'h40000000, 2'd1, 1'b1, 12'h002, 32'd0);

        // Reset while busy.
        start_op(8'h01, 32'hCAFEF00D, 32'h0, 2'd3);
        reset_n = 1'b0;
        tick;
        reset_n = 1'b1;
        expect_idle("abort_reset", 6);
        do_op("after_reset", 8'h01, 32'hCAFEF00D, 32'h0, 2'd3, 1'b0, 12'h006, 32'hCAFEF00D);

        // Flush on the very edge the counter expires.
        start_op(8'h08, 32'h3F800000, 32'h3F800000, 2'd0);
        repeat (LAT - 1) tick;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        expect_idle("flush_at_expiry", 4);

        // Stray strobes: execute in IDLE is ignored.
        execute = 1'b1;
        tick;
        execute = 1'b0;
        expect_idle("stray_execute", 3);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

`default_nettype wire
